aes_block_sequencer: RTL
========================

AES_BLOCK_SEQUENCER -- requirements
Module: aes_block_sequencer

Interface
REQ-001 Parameters: none; block size is fixed at 16 bytes, and Nk is taken from the port.
REQ-002 Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Rst  input  1  asynchronous reset, active-high.
REQ-004 Word  input  8  plaintext byte, first byte is the most significant.
REQ-005 WordValid  input  1  Word is presented this cycle.
REQ-006 WordReady  output  1  sequencer accepts a byte this cycle; high only in LOAD.
REQ-007 Nk  input  4  key length in 32-bit words: 4, 6 or 8; sampled with the first byte of a block.
REQ-008 KeySel  output  2  registered key-size select to the round datapath: 0 = Nk4, 1 = Nk6, 2 = Nk8.
REQ-009 State  output  128  current block state, driven to the round datapath.
REQ-010 RoundIn  input  128  round datapath result for the current State and RoundIdx (combinational).
REQ-011 RoundEn  output  1  round datapath step enable.
REQ-012 RoundIdx  output  4  current round number, 0..Nr.
REQ-013 LastRound  output  1  high when RoundIdx == Nr (MixColumns omitted by the datapath).
REQ-014 Out  output  128  ciphertext, valid while OutValid.
REQ-015 OutValid  output  1  ciphertext available.
REQ-016 OutReady  input  1  consumer accepts Out.
REQ-017 Busy  output  1  high in ROUND or DONE.
REQ-018 Err  output  1  one-cycle pulse on an illegal Nk.

Function
REQ-019 FSM states: LOAD, ROUND, DONE; encoding is free.
REQ-020 LOAD: a byte is accepted on an edge with WordValid && WordReady.
REQ-021 LOAD: byte k (0..15) is written to State[127-8k -: 8], and ByteCnt increments.
REQ-022 LOAD: the first byte (ByteCnt == 0) latches Nk into NkReg and updates KeySel.
REQ-023 LOAD: if Nk is not 4, 6 or 8 at the first byte, the byte is discarded, ByteCnt stays 0, Err pulses for 1 cycle, and the FSM stays in LOAD.
REQ-024 Nk changes after the first byte are ignored until the next block.
REQ-025 Acceptance of byte 15 sets the FSM to ROUND with RoundIdx = 0 and ByteCnt = 0 on the same edge.
REQ-026 ROUND: RoundEn = 1; on each edge State <= RoundIn.
REQ-027 ROUND: while RoundIdx < Nr, RoundIdx increments on each edge.
REQ-028 ROUND: Nr = NkReg + 6 (10, 12 or 14).
REQ-029 ROUND: when RoundIdx == Nr, LastRound = 1, and the next edge sets State <= RoundIn, moves the FSM to DONE and clears RoundIdx to 0.
REQ-030 ROUND lasts Nr+1 cycles (round 0 = initial AddRoundKey).
REQ-031 DONE: OutValid = 1, Out = State, RoundEn = 0.
REQ-032 DONE: Out is held stable until OutValid && OutReady; that edge moves the FSM to LOAD.
REQ-033 Latency: OutValid rises Nr+1 cycles after the edge accepting byte 15 (11 / 13 / 15 cycles).
REQ-034 Throughput: WordReady is 0 in ROUND and DONE; WordValid is ignored there, with no buffering.
REQ-035 WordValid with WordReady low never changes State or ByteCnt.
REQ-036 OutReady outside DONE is ignored.
REQ-037 RoundIdx never exceeds Nr; ByteCnt wraps 15 -> 0 only via REQ-025.

Reset
REQ-038 Rst high forces asynchronously: FSM = LOAD, ByteCnt = 0, NkReg = 4, KeySel = 0, State = 0, RoundIdx = 0.
REQ-039 Rst high forces asynchronously: RoundEn = 0, LastRound = 0, OutValid = 0, Out = 0, Busy = 0, Err = 0, WordReady = 1.
REQ-040 Reset mid-load or mid-round discards the partial block and any result; there is no output pulse.

Verification
REQ-041 Nk = 4, bytes 00,11,...,ff on consecutive cycles -> after byte 15, State = 128'h00112233445566778899aabbccddeeff, KeySel = 0, RoundIdx steps 0..10, LastRound only at 10, OutValid after 11 cycles.
REQ-042 Nk = 8 with the FIPS-197 round datapath and key 000102..1f -> Out = 128'h8ea2b7ca516745bfeafc49904b496089 after 15 cycles; Nk = 6 -> 128'hdda97ca4864cdfe06eaf70a0ec0d7191 after 13 cycles.
REQ-043 Nk = 5 on the first byte -> Err one cycle, ByteCnt stays 0; then Nk = 4 and 16 bytes -> normal completion.
REQ-044 OutReady held low 20 cycles in DONE -> Out stable, WordReady = 0, stray WordValid ignored; OutReady = 1 -> LOAD next cycle.
REQ-045 WordValid gapped (every 3rd cycle) -> identical State to REQ-041.
REQ-046 Rst asserted at byte 7 and again at RoundIdx = 5 -> all outputs at reset values immediately; the next full block completes correctly.

Source files
------------

// File: rtl/aes_block_sequencer.sv
// Sequences 16-byte AES blocks: loads bytes MSB-first, steps an external round
// datapath through rounds 0..Nr, then holds the ciphertext until the consumer accepts it.
module aes_block_sequencer (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [7:0]   Word,
  input  logic         WordValid,
  output logic         WordReady,
  input  logic [3:0]   Nk,
  output logic [1:0]   KeySel,
  output logic [127:0] State,
  input  logic [127:0] RoundIn,
  output logic         RoundEn,
  output logic [3:0]   RoundIdx,
  output logic         LastRound,
  output logic [127:0] Out,
  output logic         OutValid,
  input  logic         OutReady,
  output logic         Busy,
  output logic         Err,
  output logic [1:0]   DbgState
);
  // Handshakes: a transfer happens on a rising Clk edge where valid && ready are
  // both high; ready never depends on valid, and Out is held until accepted.
  typedef enum logic [1:0] {LOAD = 2'd0, ROUND = 2'd1, DONE = 2'd2} fsm_t;

  fsm_t       fsm;
  logic [3:0] byte_cnt;
  logic [3:0] nk_reg;
  logic [3:0] nr;
  logic       nk_legal;
  logic       accept;

  assign nk_legal = (Nk == 4'd4) || (Nk == 4'd6) || (Nk == 4'd8);
  assign nr       = nk_reg + 4'd6;
  assign accept   = WordValid && WordReady;
  assign DbgState = fsm;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      fsm       <= LOAD;
      byte_cnt  <= 4'd0;
      nk_reg    <= 4'd4;
      KeySel    <= 2'd0;
      State     <= '0;
      RoundIdx  <= 4'd0;
      RoundEn   <= 1'b0;
      LastRound <= 1'b0;
      OutValid  <= 1'b0;
      Out       <= '0;
      Busy      <= 1'b0;
      Err       <= 1'b0;
      WordReady <= 1'b1;
    end else begin
      Err <= 1'b0;
      case (fsm)
        LOAD: begin
          if (accept) begin
            // An illegal key length on the first byte drops that byte entirely.
            if (byte_cnt == 4'd0 && !nk_legal) begin
              Err <= 1'b1;
            end else begin
              for (int i = 0; i < 16; i++) begin
                if (byte_cnt == 4'(i)) State[127-8*i -: 8] <= Word;
              end
              if (byte_cnt == 4'd0) begin
                nk_reg <= Nk;
                KeySel <= (Nk == 4'd8) ? 2'd2 : (Nk == 4'd6) ? 2'd1 : 2'd0;
              end
              if (byte_cnt == 4'd15) begin
                fsm       <= ROUND;
                byte_cnt  <= 4'd0;
                RoundIdx  <= 4'd0;
                RoundEn   <= 1'b1;
                LastRound <= 1'b0;
                Busy      <= 1'b1;
                WordReady <= 1'b0;
              end else begin
                byte_cnt <= byte_cnt + 4'd1;
              end
            end
          end
        end
        ROUND: begin
          State <= RoundIn;
          if (RoundIdx == nr) begin
            fsm       <= DONE;
            RoundIdx  <= 4'd0;
            RoundEn   <= 1'b0;
            LastRound <= 1'b0;
            OutValid  <= 1'b1;
            Out       <= RoundIn;
          end else begin
            RoundIdx  <= RoundIdx + 4'd1;
            LastRound <= (RoundIdx + 4'd1) == nr;
          end
        end
        DONE: begin
          if (OutReady) begin
            fsm       <= LOAD;
            OutValid  <= 1'b0;
            Out       <= '0;
            Busy      <= 1'b0;
            WordReady <= 1'b1;
          end
        end
        default: fsm <= LOAD;
      endcase
    end
  end
endmodule
